decode_queue: RTL and testbench

Parametrised decode front-end for the pipelined MIPS core: a DEPTH-entry instruction queue between fetch and the D stage, with in-queue immediate extension, branch comparison and next-PC generation. It replaces the fixed single-entry D-stage decode. It adds buffering, stall and flush handling, and configurable delay-slot semantics. Branches resolve in D against operand values that have already been forwarded. The queue itself discards wrong-path entries on redirect.

---
 rtl/decode_queue.sv | 161 ++++++++++++++++
 tb/tb_decode_queue.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// decode_queue: DEPTH-entry instruction queue between fetch and the D stage.
// The head entry is decoded in place: immediate extension, branch compare
// against forwarded operands, and next-PC / link-address generation.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_valid/in_pc/in_instr    fetch offer; in_ready = room available
//   stall                      hazard unit holds the head
//   flush                      exception/eret flush, empties the queue
//   rs_addr/rt_addr            head register specifiers
//   rs_data/rt_data            forwarded operand values for the head
//   out_valid/out_pc/out_instr head entry and its issuability
//   imm32                      extended immediate of the head
//   redirect_valid/_pc         taken control transfer issued this cycle
//   link_pc                    return address for jal/jalr
//   count                      occupancy
//
// Build option: define DECODE_QUEUE_DELAY_SLOT_EN for MIPS delay-slot
// semantics (branch waits for its slot, slot survives the redirect).
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_instr,
    output logic             in_ready,
    input  logic             stall,
    input  logic             flush,
    output logic [4:0]       rs_addr,
    output logic [4:0]       rt_addr,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      rt_data,
    output logic             out_valid,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_instr,
    output logic [31:0]      imm32,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic [31:0]      link_pc,
    output logic [PTR_W:0]   count
);

    logic [31:0]      pc_q    [DEPTH];
    logic [31:0]      instr_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   count_q;

    logic        nonempty, push, pop, is_ctrl, taken;
    logic [31:0] head_pc, head_instr, pc_plus4, target;
    logic [5:0]  opcode, funct;
    logic [15:0] imm16;

    assign nonempty   = (count_q != '0);
    assign head_pc    = nonempty ? pc_q[rd_ptr]    : '0;
    assign head_instr = nonempty ? instr_q[rd_ptr] : '0;
    assign opcode     = head_instr[31:26];
    assign funct      = head_instr[5:0];
    assign imm16      = head_instr[15:0];
    assign pc_plus4   = head_pc + 32'd4;

    // Control-transfer classification, branch outcome and target.
    always_comb begin
        is_ctrl = 1'b0;
        taken   = 1'b0;
        target  = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
        unique case (opcode)
            6'h00: begin
                if (funct == 6'h08 || funct == 6'h09) begin
                    is_ctrl = 1'b1;
                    taken   = 1'b1;
                    target  = rs_data;
                end
            end
            6'h01: begin
                if (head_instr[20:16] == 5'd0) begin
                    is_ctrl = 1'b1;
                    taken   = rs_data[31];
                end else if (head_instr[20:16] == 5'd1) begin
                    is_ctrl = 1'b1;
                    taken   = !rs_data[31];
                end
            end
            6'h02, 6'h03: begin
                is_ctrl = 1'b1;
                taken   = 1'b1;
                target  = {pc_plus4[31:28], head_instr[25:0], 2'b00};
            end
            6'h04: begin is_ctrl = 1'b1; taken = (rs_data == rt_data); end
            6'h05: begin is_ctrl = 1'b1; taken = (rs_data != rt_data); end
            6'h06: begin is_ctrl = 1'b1; taken = rs_data[31] || (rs_data == '0); end
            6'h07: begin is_ctrl = 1'b1; taken = !rs_data[31] && (rs_data != '0); end
            default: ;
        endcase
    end

    always_comb begin
        unique case (opcode)
            6'h0C, 6'h0D, 6'h0E: imm32 = {16'h0000, imm16};
            6'h0F:               imm32 = {imm16, 16'h0000};
            default:             imm32 = {{16{imm16[15]}}, imm16};
        endcase
    end

`ifdef DECODE_QUEUE_DELAY_SLOT_EN
    assign out_valid = nonempty && (!is_ctrl || count_q >= (PTR_W+1)'(2));
    assign link_pc   = nonempty ? head_pc + 32'd8 : '0;
`else
    assign out_valid = nonempty;
    assign link_pc   = nonempty ? pc_plus4 : '0;
`endif

    assign in_ready       = (count_q < (PTR_W+1)'(DEPTH));
    assign pop            = out_valid && !stall;
    assign redirect_valid = pop && is_ctrl && taken && !flush;
    assign push           = in_valid && in_ready && !redirect_valid && !flush;

    assign rs_addr     = head_instr[25:21];
    assign rt_addr     = head_instr[20:16];
    assign out_pc      = head_pc;
    assign out_instr   = head_instr;
    assign redirect_pc = nonempty ? target : '0;
    assign count       = count_q;

    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_ptr]    <= in_pc;
            instr_q[wr_ptr] <= in_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (redirect_valid) begin
            // Rebuild wr_ptr/count from rd_ptr so every wrong-path entry
            // younger than the branch (or its delay slot) is discarded.
            rd_ptr <= rd_ptr + PTR_W'(1);
`ifdef DECODE_QUEUE_DELAY_SLOT_EN
            wr_ptr  <= rd_ptr + PTR_W'(1) + PTR_W'(1);
            count_q <= (PTR_W+1)'(1);
`else
            wr_ptr  <= rd_ptr + PTR_W'(1);
            count_q <= '0;
`endif
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed self-checking bench for decode_queue (DEPTH=4).
// Expectations follow whichever build of DECODE_QUEUE_DELAY_SLOT_EN is used.
module tb_decode_queue;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    localparam logic [31:0] NOP   = 32'h0000_0000;
    localparam logic [31:0] BEQ   = 32'h1022_0004; // beq $1,$2,+4
    localparam logic [31:0] BNE   = 32'h1422_0004; // bne $1,$2,+4
    localparam logic [31:0] JAL   = 32'h0C00_0C00; // jal imm26=0xC00
    localparam logic [31:0] JR    = 32'h0020_0008; // jr $1
    localparam logic [31:0] ORI   = 32'h3400_8000;
    localparam logic [31:0] LUI   = 32'h3C00_8000;
    localparam logic [31:0] ANDI  = 32'h3000_FFFF;
    localparam logic [31:0] ADDI  = 32'h2000_FFFC;

    logic             clk = 1'b0;
    logic             reset, in_valid, in_ready, stall, flush;
    logic [31:0]      in_pc, in_instr, rs_data, rt_data;
    logic [4:0]       rs_addr, rt_addr;
    logic             out_valid, redirect_valid;
    logic [31:0]      out_pc, out_instr, imm32, redirect_pc, link_pc;
    logic [PTR_W:0]   count;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];
    logic        do_pop;

    decode_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
        .stall(stall), .flush(flush),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .imm32(imm32),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .link_pc(link_pc),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        step();
        reset = 1'b0;
        #1;
    endtask

    // Push one entry with the head held so nothing drains meanwhile.
    task automatic push_held(input logic [31:0] pc, input logic [31:0] instr);
        stall = 1'b1; in_valid = 1'b1; in_pc = pc; in_instr = instr;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        in_pc = '0; in_instr = '0; rs_data = 32'd5; rt_data = 32'd5;

        // Reset state
        do_reset();
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_redirect", 32'(redirect_valid), 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_link_pc", link_pc, 32'd0);

        // Fill then drain
        for (int i = 0; i < 4; i++) push_held(32'h3000 + 32'(4*i), NOP);
        #1;
        check("full_count", 32'(count), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1; in_pc = 32'h30F0; in_instr = NOP;
        step();
        in_valid = 1'b0;
        check("overfill_count", 32'(count), 32'd4);
        stall = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", 32'(out_valid), 32'd1);
            check("drain_pc", out_pc, 32'h3000 + 32'(4*i));
            step();
        end
        check("drained_valid", 32'(out_valid), 32'd0);
        check("drained_count", 32'(count), 32'd0);
        check("drained_pc", out_pc, 32'd0);

        // Wrap: 6 pushes with interleaved pops, order preserved
        exp_q.delete();
        for (int i = 0; i < 9; i++) begin
            in_valid = (i < 6);
            in_pc    = 32'h4000 + 32'(4*i);
            in_instr = NOP;
            stall    = (i == 1);
            #1;
            if (exp_q.size() > 0) check("wrap_pc", out_pc, exp_q[0]);
            check("wrap_count", 32'(count), 32'(exp_q.size()));
            do_pop = (exp_q.size() > 0) && !stall;
            step();
            if (do_pop) void'(exp_q.pop_front());
            if (in_valid) exp_q.push_back(in_pc);
        end
        in_valid = 1'b0;
        #1;
        check("wrap_empty", 32'(out_valid), 32'd0);

        // beq taken with three entries, wrong-path push in redirect cycle
        do_reset();
        push_held(32'h3000, BEQ);
        push_held(32'h3004, NOP);
        push_held(32'h3008, NOP);
        rs_data = 32'd5; rt_data = 32'd5;
        stall = 1'b0; in_valid = 1'b1; in_pc = 32'h5000; in_instr = NOP;
        #1;
        check("beq_rs_addr", 32'(rs_addr), 32'd1);
        check("beq_rt_addr", 32'(rt_addr), 32'd2);
        check("beq_redirect", 32'(redirect_valid), 32'd1);
        check("beq_target", redirect_pc, 32'h3014);
        check("beq_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        #1;
`ifdef DECODE_QUEUE_DELAY_SLOT_EN
        check("beq_ds_count", 32'(count), 32'd1);
        check("beq_ds_head", out_pc, 32'h3004);
        step();
        check("beq_ds_drained", 32'(count), 32'd0);
`else
        check("beq_count", 32'(count), 32'd0);
        check("beq_valid", 32'(out_valid), 32'd0);
`endif

        // bne not taken pops normally
        do_reset();
        push_held(32'h3000, BNE);
        push_held(32'h3004, NOP);
        stall = 1'b0;
        #1;
        check("bne_valid", 32'(out_valid), 32'd1);
        check("bne_redirect", 32'(redirect_valid), 32'd0);
        step();
        check("bne_next_pc", out_pc, 32'h3004);
        check("bne_next_count", 32'(count), 32'd1);

        // beq alone in the queue
        do_reset();
        push_held(32'h3000, BEQ);
        stall = 1'b0;
        #1;
        check("beq1_count", 32'(count), 32'd1);
`ifdef DECODE_QUEUE_DELAY_SLOT_EN
        check("beq1_ds_valid", 32'(out_valid), 32'd0);
        check("beq1_ds_redirect", 32'(redirect_valid), 32'd0);
        step();
        check("beq1_ds_hold", 32'(count), 32'd1);
`else
        check("beq1_valid", 32'(out_valid), 32'd1);
        check("beq1_target", redirect_pc, 32'h3014);
        step();
        check("beq1_after", 32'(count), 32'd0);
`endif

        // jal
        do_reset();
        in_valid = 1'b1; in_pc = 32'h3000; in_instr = JAL;
        step();
        in_valid = 1'b0;
        #1;
        check("jal_count", 32'(count), 32'd1);
`ifdef DECODE_QUEUE_DELAY_SLOT_EN
        check("jal_ds_wait", 32'(out_valid), 32'd0);
        step();
        check("jal_ds_wait2", 32'(out_valid), 32'd0);
        in_valid = 1'b1; in_pc = 32'h3004; in_instr = NOP;
        step();
        in_valid = 1'b0;
        #1;
        check("jal_ds_valid", 32'(out_valid), 32'd1);
        check("jal_ds_redirect", 32'(redirect_valid), 32'd1);
        check("jal_ds_target", redirect_pc, 32'h0000_3000);
        check("jal_ds_link", link_pc, 32'h3008);
        step();
        check("jal_ds_slot", out_pc, 32'h3004);
`else
        check("jal_valid", 32'(out_valid), 32'd1);
        check("jal_redirect", 32'(redirect_valid), 32'd1);
        check("jal_target", redirect_pc, 32'h0000_3000);
        check("jal_link", link_pc, 32'h3004);
        step();
        check("jal_after", 32'(count), 32'd0);
`endif

        // jr uses forwarded rs
        do_reset();
        push_held(32'h3000, JR);
        push_held(32'h3004, NOP);
        rs_data = 32'h1234_5678;
        stall = 1'b0;
        #1;
        check("jr_redirect", 32'(redirect_valid), 32'd1);
        check("jr_target", redirect_pc, 32'h1234_5678);
        rs_data = 32'd5;

        // Stall with ori head while pushes fill the queue
        do_reset();
        push_held(32'h3000, ORI);
        for (int k = 0; k < 3; k++) begin
            stall = 1'b1; in_valid = 1'b1; in_pc = 32'h3004 + 32'(4*k); in_instr = NOP;
            #1;
            check("stall_imm", imm32, 32'h0000_8000);
            check("stall_pc", out_pc, 32'h3000);
            step();
        end
        in_valid = 1'b0;
        #1;
        check("stall_count", 32'(count), 32'd4);
        check("stall_full", 32'(in_ready), 32'd0);
        stall = 1'b0;
        step();
        check("unstall_pc", out_pc, 32'h3004);
        check("unstall_count", 32'(count), 32'd3);

        // Immediate extension variants
        do_reset();
        push_held(32'h3000, LUI);
        check("lui_imm", imm32, 32'h8000_0000);
        do_reset();
        push_held(32'h3000, ANDI);
        check("andi_imm", imm32, 32'h0000_FFFF);
        do_reset();
        push_held(32'h3000, ADDI);
        check("addi_imm", imm32, 32'hFFFF_FFFC);

        // Flush with count=3, concurrent push and a taken branch head
        do_reset();
        push_held(32'h3000, BEQ);
        push_held(32'h3004, NOP);
        push_held(32'h3008, NOP);
        stall = 1'b0; flush = 1'b1; in_valid = 1'b1; in_pc = 32'h6000; in_instr = NOP;
        #1;
        check("flush_redirect", 32'(redirect_valid), 32'd0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("flush_count", 32'(count), 32'd0);
        check("flush_valid", 32'(out_valid), 32'd0);

        // Reset mid-stream while stalled
        push_held(32'h3000, NOP);
        push_held(32'h3004, NOP);
        push_held(32'h3008, NOP);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
